// File: rtl/vga_rect_blitter_if.sv
// vga_rect_blitter_if: command channel and pixel-write channel of the rectangle blitter
interface vga_rect_blitter_if #(
  parameter int nX          = 10,
  parameter int nY          = 9,
  parameter int COLOR_DEPTH = 9
);
  logic                   cmd_valid;
  logic                   cmd_ready;
  logic [1:0]             cmd_mode;
  logic [nX-1:0]          cmd_x0;
  logic [nX-1:0]          cmd_x1;
  logic [nY-1:0]          cmd_y0;
  logic [nY-1:0]          cmd_y1;
  logic [COLOR_DEPTH-1:0] cmd_color;
  logic [nX-1:0]          pix_x;
  logic [nY-1:0]          pix_y;
  logic [COLOR_DEPTH-1:0] pix_color;
  logic                   pix_write;
  logic                   pix_ready;
  logic                   busy;
  logic                   done;
  modport master (
    output cmd_valid, cmd_mode, cmd_x0, cmd_x1, cmd_y0, cmd_y1, cmd_color, pix_ready,
    input  cmd_ready, pix_x, pix_y, pix_color, pix_write, busy, done
  );
  modport slave (
    input  cmd_valid, cmd_mode, cmd_x0, cmd_x1, cmd_y0, cmd_y1, cmd_color, pix_ready,
    output cmd_ready, pix_x, pix_y, pix_color, pix_write, busy, done
  );
endinterface

// File: rtl/vga_rect_blitter.sv
// vga_rect_blitter: raster pixel-write engine for fill/outline/clear/pixel commands; define VGA_BLIT_CLIP_EN to clip to the screen
module vga_rect_blitter #(
  parameter     RESOLUTION  = "640x480",
  parameter int COLOR_DEPTH = 9
) (
  input logic               clock,
  input logic               resetn,
  vga_rect_blitter_if.slave bus
);
  localparam int COLS = RESOLUTION == "320x240" ? 320 : RESOLUTION == "160x120" ? 160 : 640;
  localparam int ROWS = COLS * 3 / 4;
  localparam int nX = $clog2(COLS);
  localparam int nY = $clog2(ROWS);
  localparam logic [nX-1:0] X_MAX = nX'(COLS - 1);
  localparam logic [nY-1:0] Y_MAX = nY'(ROWS - 1);
  typedef enum logic {IDLE, DRAW} state_t;
  state_t state, state_next;
  logic [nX-1:0] xa, xb, x, x_next, lo_x, hi_x, nxa, nxb;
  logic [nY-1:0] ya, yb, y, y_next, lo_y, hi_y, nya, nyb;
  logic [COLOR_DEPTH-1:0] color;
  logic outline, done_q, done_next, accept, fire, last, empty;
  // Normalise the incoming corners per mode, optionally clipping to the screen
  always_comb begin
    lo_x = bus.cmd_x0 < bus.cmd_x1 ? bus.cmd_x0 : bus.cmd_x1;
    hi_x = bus.cmd_x0 < bus.cmd_x1 ? bus.cmd_x1 : bus.cmd_x0;
    lo_y = bus.cmd_y0 < bus.cmd_y1 ? bus.cmd_y0 : bus.cmd_y1;
    hi_y = bus.cmd_y0 < bus.cmd_y1 ? bus.cmd_y1 : bus.cmd_y0;
    nxa = bus.cmd_mode == 2'b10 ? '0 : bus.cmd_mode == 2'b11 ? bus.cmd_x0 : lo_x;
    nxb = bus.cmd_mode == 2'b10 ? X_MAX : bus.cmd_mode == 2'b11 ? bus.cmd_x0 : hi_x;
    nya = bus.cmd_mode == 2'b10 ? '0 : bus.cmd_mode == 2'b11 ? bus.cmd_y0 : lo_y;
    nyb = bus.cmd_mode == 2'b10 ? Y_MAX : bus.cmd_mode == 2'b11 ? bus.cmd_y0 : hi_y;
`ifdef VGA_BLIT_CLIP_EN
    empty = nxa > X_MAX || nya > Y_MAX;
    nxb = nxb > X_MAX ? X_MAX : nxb;
    nyb = nyb > Y_MAX ? Y_MAX : nyb;
`else
    empty = 1'b0;
`endif
  end
  // Next state, raster step (outline skips row interiors) and completion pulse
  always_comb begin
    accept = bus.cmd_valid && state == IDLE;
    fire = state == DRAW && bus.pix_ready;
    last = x == xb && y == yb;
    state_next = state;
    if (accept && !empty) state_next = DRAW;
    if (fire && last) state_next = IDLE;
    done_next = (accept && empty) || (fire && last);
    x_next = x == xb ? xa : (outline && x == xa && y != ya && y != yb) ? xb : x + 1'b1;
    y_next = x == xb ? y + 1'b1 : y;
  end
  // State register
  always_ff @(posedge clock)
    if (!resetn) state <= IDLE;
    else state <= state_next;
  // Command registers, scan position and done pulse
  always_ff @(posedge clock)
    if (!resetn) begin
      xa <= '0;
      xb <= '0;
      ya <= '0;
      yb <= '0;
      x <= '0;
      y <= '0;
      color <= '0;
      outline <= 1'b0;
      done_q <= 1'b0;
    end else begin
      done_q <= done_next;
      if (accept) begin
        xa <= nxa;
        xb <= nxb;
        ya <= nya;
        yb <= nyb;
        x <= nxa;
        y <= nya;
        color <= bus.cmd_color;
        outline <= bus.cmd_mode == 2'b01;
      end else if (fire && !last) begin
        x <= x_next;
        y <= y_next;
      end
    end
  assign bus.cmd_ready = state == IDLE;
  assign bus.busy = state == DRAW;
  assign bus.pix_write = state == DRAW;
  assign bus.done = done_q;
  assign bus.pix_x = x;
  assign bus.pix_y = y;
  assign bus.pix_color = color;
endmodule

// File: tb/tb_vga_rect_blitter.sv
// tb_vga_rect_blitter: directed commands on a 160x120 blitter against a pixel-set model
module tb_vga_rect_blitter;
  localparam int COLS = 160;
  localparam int ROWS = 120;
`ifdef VGA_BLIT_CLIP_EN
  localparam int CF_N = 100, CF_LX = 159, CF_LY = 119, CO_N = 26, CP_N = 0;
`else
  localparam int CF_N = 816, CF_LX = 200, CF_LY = 125, CO_N = 120, CP_N = 2;
`endif
  typedef struct packed {int x; int y;} pt_t;
  logic clk = 1'b0;
  logic resetn = 1'b0;
  int passed = 0, total = 0, cyc = 0, done_cnt = 0, busy_cnt = 0, n0 = 0, lat = 0, d0 = 0;
  int exp_color = 0;
  pt_t exp_q[$];
  pt_t obs_q[$];
  bit chk_en = 0, done_exp = 0, was_rst = 0, idle = 0, dn = 0;

  vga_rect_blitter_if #(.nX(8), .nY(7), .COLOR_DEPTH(9)) bus ();
  vga_rect_blitter #(.RESOLUTION("160x120"), .COLOR_DEPTH(9)) dut (.clock(clk), .resetn(resetn), .bus(bus));

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
  endtask

  // Expected pixel set of a command, listed in raster order
  function automatic void build(input int mode, input int x0, input int y0, input int x1, input int y1, input int col);
    int xa, xb, ya, yb;
    pt_t p;
    exp_color = col;
    xa = x0 < x1 ? x0 : x1;
    xb = x0 < x1 ? x1 : x0;
    ya = y0 < y1 ? y0 : y1;
    yb = y0 < y1 ? y1 : y0;
    if (mode == 3) begin xa = x0; xb = x0; ya = y0; yb = y0; end
    if (mode == 2) begin xa = 0; xb = COLS - 1; ya = 0; yb = ROWS - 1; end
`ifdef VGA_BLIT_CLIP_EN
    if (xa >= COLS || ya >= ROWS) return;
    if (xb > COLS - 1) xb = COLS - 1;
    if (yb > ROWS - 1) yb = ROWS - 1;
`endif
    for (int yy = ya; yy <= yb; yy++)
      for (int xx = xa; xx <= xb; xx++)
        if (mode != 1 || yy == ya || yy == yb || xx == xa || xx == xb) begin
          p.x = xx;
          p.y = yy;
          exp_q.push_back(p);
        end
  endfunction

  // Observed handshaked pixels, done pulses and busy cycles
  always @(negedge clk) begin
    pt_t p;
    if (bus.pix_write && bus.pix_ready) begin
      p.x = int'(bus.pix_x);
      p.y = int'(bus.pix_y);
      obs_q.push_back(p);
    end
    if (bus.done) done_cnt++;
    if (bus.busy) busy_cnt++;
  end

  // Per-cycle comparison against the model, then model advance for the coming edge
  always @(negedge clk) if (chk_en) begin
    idle = exp_q.size() == 0;
    check("pix_write", int'(bus.pix_write), int'(!idle));
    check("busy", int'(bus.busy), int'(!idle));
    check("cmd_ready", int'(bus.cmd_ready), int'(idle));
    check("done", int'(bus.done), int'(done_exp));
    if (!idle) begin
      check("pix_x", int'(bus.pix_x), exp_q[0].x);
      check("pix_y", int'(bus.pix_y), exp_q[0].y);
      check("pix_color", int'(bus.pix_color), exp_color);
    end
    if (was_rst) begin
      check("rst_pix_x", int'(bus.pix_x), 0);
      check("rst_pix_y", int'(bus.pix_y), 0);
      check("rst_pix_color", int'(bus.pix_color), 0);
    end
    dn = 0;
    if (!resetn) exp_q.delete();
    else if (!idle && bus.pix_ready) begin
      void'(exp_q.pop_front());
      dn = exp_q.size() == 0;
    end else if (idle && bus.cmd_valid) begin
      build(int'(bus.cmd_mode), int'(bus.cmd_x0), int'(bus.cmd_y0), int'(bus.cmd_x1), int'(bus.cmd_y1), int'(bus.cmd_color));
      dn = exp_q.size() == 0;
    end
    was_rst = !resetn;
    done_exp = dn;
  end

  task automatic issue(input int mode, input int x0, input int y0, input int x1, input int y1, input int col);
    obs_q.delete();
    busy_cnt = 0;
    bus.cmd_mode = 2'(mode);
    bus.cmd_x0 = 8'(x0);
    bus.cmd_y0 = 7'(y0);
    bus.cmd_x1 = 8'(x1);
    bus.cmd_y1 = 7'(y1);
    bus.cmd_color = 9'(col);
    bus.cmd_valid = 1'b1;
    @(posedge clk);
    #1;
    n0 = cyc;
    bus.cmd_valid = 1'b0;
  endtask

  task automatic wait_done(input string name, input int budget);
    while (!bus.done && cyc - n0 < budget) begin
      @(posedge clk);
      #1;
    end
    check({name, "_done_seen"}, int'(bus.done), 1);
    lat = cyc - n0;
  endtask

  task automatic chk_pt(input string name, input int i, input int x, input int y);
    check({name, "_x"}, obs_q.size() > i ? obs_q[i].x : -1, x);
    check({name, "_y"}, obs_q.size() > i ? obs_q[i].y : -1, y);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    bus.cmd_valid = 1'b0;
    bus.cmd_mode = '0;
    bus.cmd_x0 = '0;
    bus.cmd_y0 = '0;
    bus.cmd_x1 = '0;
    bus.cmd_y1 = '0;
    bus.cmd_color = '0;
    bus.pix_ready = 1'b1;
    @(posedge clk);
    #1;
    chk_en = 1;
    repeat (2) @(posedge clk);
    #1;
    resetn = 1'b1;
    @(posedge clk);
    #1;
    check("reset_cmd_ready", int'(bus.cmd_ready), 1);
    check("reset_busy", int'(bus.busy), 0);
    check("reset_pix_write", int'(bus.pix_write), 0);
    check("reset_done", int'(bus.done), 0);
    check("reset_pix_x", int'(bus.pix_x), 0);
    issue(0, 3, 4, 4, 5, 'h1FF);
    wait_done("fill", 50);
    check("fill_lat", lat, 4);
    check("fill_n", obs_q.size(), 4);
    chk_pt("fill_p0", 0, 3, 4);
    chk_pt("fill_p1", 1, 4, 4);
    chk_pt("fill_p2", 2, 3, 5);
    chk_pt("fill_p3", 3, 4, 5);
    issue(0, 4, 5, 3, 4, 'h1FF);
    wait_done("swap", 50);
    check("swap_lat", lat, 4);
    chk_pt("swap_p0", 0, 3, 4);
    chk_pt("swap_p3", 3, 4, 5);
    issue(1, 10, 10, 13, 12, 'h0A5);
    bus.cmd_mode = 2'b10;
    bus.cmd_valid = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    bus.cmd_valid = 1'b0;
    wait_done("outline", 50);
    check("outline_lat", lat, 10);
    check("outline_n", obs_q.size(), 10);
    chk_pt("outline_p3", 3, 13, 10);
    chk_pt("outline_p4", 4, 10, 11);
    chk_pt("outline_p5", 5, 13, 11);
    chk_pt("outline_p9", 9, 13, 12);
    issue(1, 5, 5, 5, 8, 'h011);
    wait_done("outline_w1", 50);
    check("outline_w1_n", obs_q.size(), 4);
    chk_pt("outline_w1_p3", 3, 5, 8);
    bus.pix_ready = 1'b0;
    issue(0, 20, 30, 21, 30, 'h123);
    repeat (3) @(posedge clk);
    #1;
    bus.pix_ready = 1'b1;
    wait_done("stall", 50);
    check("stall_lat", lat, 5);
    check("stall_busy", busy_cnt, 5);
    chk_pt("stall_p1", 1, 21, 30);
    issue(3, 7, 9, 100, 50, 'h0F0);
    wait_done("pixel", 50);
    check("pixel_lat", lat, 1);
    chk_pt("pixel_p0", 0, 7, 9);
    issue(0, 150, 110, 200, 125, 'h0AA);
    wait_done("clipfill", 2000);
    check("clipfill_n", obs_q.size(), CF_N);
    chk_pt("clipfill_last", CF_N - 1, CF_LX, CF_LY);
    issue(1, 200, 125, 150, 115, 'h055);
    wait_done("clipoutline", 2000);
    check("clipoutline_n", obs_q.size(), CO_N);
    issue(0, 200, 5, 200, 6, 'h077);
    wait_done("clipempty", 50);
    check("clipempty_lat", lat, CP_N);
    check("clipempty_n", obs_q.size(), CP_N);
    issue(2, 37, 11, 2, 99, 0);
    wait_done("clear", 20000);
    check("clear_lat", lat, COLS * ROWS);
    check("clear_n", obs_q.size(), COLS * ROWS);
    chk_pt("clear_first", 0, 0, 0);
    chk_pt("clear_last", COLS * ROWS - 1, 159, 119);
    issue(2, 0, 0, 0, 0, 'h1C3);
    while (obs_q.size() < 50 && cyc - n0 < 200) begin
      @(posedge clk);
      #1;
    end
    check("abort_reach50", obs_q.size(), 50);
    resetn = 1'b0;
    d0 = done_cnt;
    @(posedge clk);
    #1;
    check("abort_pix_write", int'(bus.pix_write), 0);
    check("abort_busy", int'(bus.busy), 0);
    resetn = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("abort_no_done", done_cnt, d0);
    check("abort_cmd_ready", int'(bus.cmd_ready), 1);
    issue(0, 0, 0, 1, 0, 5);
    wait_done("after_abort", 50);
    check("after_abort_lat", lat, 2);
    chk_pt("after_abort_p1", 1, 1, 0);
    @(posedge clk);
    #1;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/vga_rect_blitter.md
# vga_rect_blitter

Rectangle drawing engine placed in front of the VGA adapter's pixel-write port (`x`, `y`, `color`, `write`). It accepts one drawing command at a time over a valid/ready handshake: filled rectangle, outline rectangle, single pixel, or full-screen clear. It then emits the corresponding pixel writes in raster order, one per accepted cycle, with downstream back-pressure. The block is generalised over resolution and color depth, and replaces per-pixel write loops in user FSMs.

## Interface
- `RESOLUTION`, "640x480", one of "640x480", "320x240", "160x120"
- `COLOR_DEPTH`, 9, bits per pixel
- `nX`, 10/9/8 derived from `RESOLUTION`, X coordinate width
- `nY`, 9/8/7 derived from `RESOLUTION`, Y coordinate width
- `COLS`, 640/320/160 derived, screen columns
- `ROWS`, 480/240/120 derived, screen rows

Ports:
- `clock` in 1: sole clock; all state updates on its rising edge.
- `resetn` in 1: synchronous, active-low reset.
- `cmd_valid` in 1: command present.
- `cmd_ready` out 1: block can accept a command.
- `cmd_mode` in 2: 00 fill, 01 outline, 10 clear, 11 single pixel at (`cmd_x0`,`cmd_y0`).
- `cmd_x0`, `cmd_x1` in nX: corner X coordinates.
- `cmd_y0`, `cmd_y1` in nY: corner Y coordinates.
- `cmd_color` in COLOR_DEPTH: draw color.
- `pix_x` out nX, `pix_y` out nY, `pix_color` out COLOR_DEPTH: current pixel.
- `pix_write` out 1: pixel valid.
- `pix_ready` in 1: downstream accepts the pixel; tie to 1 for a direct adapter connection.
- `busy` out 1: command in progress.
- `done` out 1: one-cycle pulse when a command completes.

## Operation
- States:
  - IDLE: `cmd_ready`=1.
  - DRAW: `pix_write`=1.
- Reset: state IDLE. `pix_x`, `pix_y`, `pix_color`, `pix_write`, `busy`, `done` all 0; `cmd_ready`=1 from the first cycle after reset.
- Accept: `cmd_valid`&&`cmd_ready` at a clock edge.
  - Operands are registered and normalised: xa=min(x0,x1), xb=max(x0,x1), likewise ya/yb.
  - Clear: xa=0, xb=COLS-1, ya=0, yb=ROWS-1; corner inputs ignored.
  - Single pixel: xa=xb=x0, ya=yb=y0.
- Scan order: x from xa to xb; at xb, x wraps to xa and y increments. The last pixel is (xb,yb).
- Outline: on rows strictly between ya and yb, x jumps from xa directly to xb.
  - Pixel count is 2w+2h-4 for w,h≥2.
  - If w==1 or h==1, outline is identical to fill.
- Pixel handshake:
  - `pix_x`/`pix_y`/`pix_color` are held stable while `pix_write`&&!`pix_ready`.
  - The scan advances only on an edge where `pix_write`&&`pix_ready`.
- Completion: the handshake of the last pixel moves the state to IDLE.
  - In the following cycle `done`=1, `busy`=0, `cmd_ready`=1 and `pix_write`=0.
  - A new command may be accepted in that same cycle.
- `cmd_valid` while busy is ignored; no queueing.
- Mid-command reset (`resetn`=0 at an edge): the command is abandoned, all outputs take their reset values, and no `done` pulse is produced.

## Timing
- Command accepted at edge N: `pix_write`=1 with the first pixel during cycle N+1. Outputs are registered.
- Throughput: 1 pixel/cycle with `pix_ready`=1.
- Duration: a command of P pixels with no stalls finishes with `done` in cycle N+P+1.
- `busy` = (state==DRAW). `cmd_ready` = !`busy` and is not combinationally dependent on `cmd_valid`.

## Configuration
- `VGA_BLIT_CLIP_EN` defined:
  - After normalisation, xb is clamped to COLS-1 and yb to ROWS-1.
  - If xa≥COLS or ya≥ROWS, the command emits no pixels. `done` pulses in the cycle after acceptance and `pix_write` stays 0.
  - Outline edges are taken on the clipped rectangle.
- Not defined:
  - No clamping; out-of-range pixels are emitted and cost cycles. The adapter discards them.
  - Clear mode is unaffected either way.

## Test plan
- 160x120, fill (3,4)-(4,5), color 0x1FF, `pix_ready`=1 → pixels (3,4),(4,4),(3,5),(4,5) in cycles N+1..N+4; `done` in N+5.
- Fill with swapped corners (4,5)-(3,4) → same sequence as above.
- Outline (10,10)-(13,12) → 10 pixels: (10..13,10), (10,11), (13,11), (10..13,12); `done` after the 10th.
- Fill 2x1 with `pix_ready` low for 3 cycles on the first pixel → (x,y,color) held for 4 cycles; total `busy` 5 cycles.
- 640x480 with `VGA_BLIT_CLIP_EN`, fill (630,470)-(700,500) → last pixel (639,479), 100 pixels. Fill with x0=x1=650 → zero pixels, `done` at N+1.
- 160x120 clear, color 0 → 19200 pixels ending at (159,119). Assert `resetn`=0 after pixel 50 → `pix_write`=0 next cycle, no `done`, `cmd_ready`=1 after reset release.
